hazard_resolution_unit: RTL and testbench
=========================================

# hazard_resolution_unit

Clocked consumer of the hazard detector's outputs: turns load-use and ALU-ALU hazard flags, operand-forward codes and branch-taken/flush requests into pipeline stall, bubble, flush and PC-redirect controls. It also drives the EXE-stage ALU operand muxes. It sits between the hazard detector and the IF/ID, ID/EXE pipeline registers and PC logic of the 5-stage MIPS core. A saturating stall-cycle counter is provided for performance observation.

## Interface
- FLUSH_CYCLES, 2: cycles IF/ID flush and ID/EXE bubble are held after a taken branch (1..15)
- CNT_W, 16: width of stall-cycle counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- branch_taken_i  in  1  flush request from hazard detector
- target_branch_address_i  in  32  branch target, valid with branch_taken_i
- load_use_dh_i  in  1  load-use hazard for instruction in ID
- alu_alu_dh_i  in  1  ALU-ALU hazard for instruction in ID
- operand_fwd_i  in  2  bit0: forward to operand A (Rs); bit1: forward to operand B (Rt)
- rs_data_i / rt_data_i  in  32 each  ID/EXE-registered operands
- exe_result_i  in  32  ALU result of instruction now leaving EXE
- ma_load_data_i  in  32  load data of instruction now in MA
- pc_stall_o, ifid_stall_o  out  1 each  hold PC and IF/ID register
- idex_bubble_o  out  1  load NOP into ID/EXE
- ifid_flush_o  out  1  clear IF/ID
- pc_redirect_o  out  1  load pc_target_o into PC
- pc_target_o  out  32  registered branch target
- alu_op_a_o / alu_op_b_o  out  32 each  forwarded or register operands
- fwd_active_o  out  2  forward select currently applied
- stall_count_o  out  CNT_W  saturating count of LU_STALL and FLUSH cycles

## Operation
- States: RUN, LU_STALL, FLUSH. Reset -> RUN.
- Priority each cycle: branch_taken_i > load_use_dh_i > alu_alu_dh_i.
- A hazard flag with operand_fwd_i == 2'b00 is ignored.
- RUN + branch_taken_i -> FLUSH:
  - capture target into pc_target_o; flush counter = FLUSH_CYCLES-1; fwd select cleared.
- RUN + load_use_dh_i -> LU_STALL:
  - capture operand_fwd_i into pending select, source = MA.
- RUN + alu_alu_dh_i (state stays RUN):
  - fwd select = operand_fwd_i, source = EXE, applied for exactly the next cycle.
- LU_STALL lasts one cycle, then -> RUN.
  - On exit, pending select applied for one cycle with source MA.
  - branch_taken_i during LU_STALL -> FLUSH; pending select discarded.
- FLUSH: counter decrements each cycle; at 0 -> RUN.
  - branch_taken_i in FLUSH reloads counter and target and re-asserts redirect.
  - load-use/ALU-ALU flags ignored in LU_STALL and FLUSH.
- Operand muxes (combinational from registered select):
  - alu_op_a_o = fwd_active_o[0] ? (src==EXE ? exe_result_i : ma_load_data_i) : rs_data_i
  - alu_op_b_o = same selection on bit1, default rt_data_i.
- stall_count_o increments by 1 each cycle state is LU_STALL or FLUSH; saturates at all-ones, never wraps.

## Timing
- Hazard inputs sampled at rising edge t; all control outputs are registered and valid in cycle t+1.
- LU_STALL cycle (t+1): pc_stall_o = ifid_stall_o = idex_bubble_o = 1. Cycle t+2: fwd_active_o = captured code, source MA.
- ALU-ALU: fwd_active_o = code in cycle t+1 only; no stall asserted.
- Branch at t:
  - pc_redirect_o = 1 in t+1 only.
  - ifid_flush_o = idex_bubble_o = 1 for cycles t+1 .. t+FLUSH_CYCLES.
  - pc_stall_o = 0 throughout.
- Reset values: state RUN, every 1-bit output 0, fwd_active_o 0, pc_target_o 0, stall_count_o 0.
  - alu_op_a_o/alu_op_b_o pass rs_data_i/rt_data_i.
- Reset asserted mid-LU_STALL or mid-FLUSH: all outputs to reset values asynchronously; pending select and counter cleared.
- Simultaneous load_use_dh_i and alu_alu_dh_i: load-use path only.

## Test plan
- ALU-ALU, code 2'b11, exe_result_i = 0x00001234, rs = 5, rt = 6 -> next cycle both operands 0x00001234, fwd_active_o = 3, no stall; following cycle operands 5/6.
- Load-use, code 2'b01, ma_load_data_i = 0xDEADBEEF -> t+1: pc_stall_o, ifid_stall_o, idex_bubble_o = 1; t+2: alu_op_a_o = 0xDEADBEEF, alu_op_b_o = rt_data_i, stalls 0.
- Branch, target 0x00000040, FLUSH_CYCLES = 2, load_use_dh_i also high -> pc_redirect_o 1 cycle with pc_target_o = 0x40; flush/bubble 2 cycles; no LU_STALL; stall_count_o = 2.
- Load-use at t, branch (target 0x80) at t+1 -> FLUSH entered, pc_target_o = 0x80, no MA forwarding afterwards.
- Reset pulse in 2nd FLUSH cycle -> all outputs 0 immediately; after release, RUN with no residual flush.
- CNT_W = 2, five back-to-back load-use events -> stall_count_o reaches 3 and holds at 3.

Source files
------------

// File: rtl/hazard_resolution_unit_if.sv
// Signal bundle between the hazard detector / pipeline datapath and the hazard resolution unit.
// The slave modport is the resolution unit's view; master is the view of whatever drives it.
interface hazard_resolution_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             branch_taken_i;
  logic [31:0]      target_branch_address_i;
  logic             load_use_dh_i;
  logic             alu_alu_dh_i;
  logic [1:0]       operand_fwd_i;
  logic [31:0]      rs_data_i;
  logic [31:0]      rt_data_i;
  logic [31:0]      exe_result_i;
  logic [31:0]      ma_load_data_i;
  logic             pc_stall_o;
  logic             ifid_stall_o;
  logic             idex_bubble_o;
  logic             ifid_flush_o;
  logic             pc_redirect_o;
  logic [31:0]      pc_target_o;
  logic [31:0]      alu_op_a_o;
  logic [31:0]      alu_op_b_o;
  logic [1:0]       fwd_active_o;
  logic [CNT_W-1:0] stall_count_o;

  modport slave (
    input  branch_taken_i, target_branch_address_i, load_use_dh_i, alu_alu_dh_i,
           operand_fwd_i, rs_data_i, rt_data_i, exe_result_i, ma_load_data_i,
    output pc_stall_o, ifid_stall_o, idex_bubble_o, ifid_flush_o, pc_redirect_o,
           pc_target_o, alu_op_a_o, alu_op_b_o, fwd_active_o, stall_count_o
  );

  modport master (
    output branch_taken_i, target_branch_address_i, load_use_dh_i, alu_alu_dh_i,
           operand_fwd_i, rs_data_i, rt_data_i, exe_result_i, ma_load_data_i,
    input  pc_stall_o, ifid_stall_o, idex_bubble_o, ifid_flush_o, pc_redirect_o,
           pc_target_o, alu_op_a_o, alu_op_b_o, fwd_active_o, stall_count_o
  );
endinterface

// File: rtl/hazard_resolution_unit.sv
// Converts hazard detector flags into registered stall/bubble/flush/redirect controls
// for a 5-stage MIPS pipeline, and drives the EXE-stage ALU operand forwarding muxes.
module hazard_resolution_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hazard_resolution_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  localparam logic SRC_EXE = 1'b0;
  localparam logic SRC_MA  = 1'b1;
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r, state_next_s;
  logic [3:0]       flush_cnt_r, flush_cnt_next_s;
  logic [1:0]       pending_r, pending_next_s;
  logic [1:0]       fwd_active_r, fwd_next_s;
  logic             fwd_src_r, fwd_src_next_s;
  logic [31:0]      pc_target_r, target_next_s;
  logic             pc_redirect_r, redirect_next_s;
  logic             pc_stall_r, ifid_flush_r, idex_bubble_r;
  logic [CNT_W-1:0] stall_count_r;
  logic             lu_valid_s, aa_valid_s;

  // Hazard flags without any operand to forward carry no work and are ignored.
  assign lu_valid_s = hz.load_use_dh_i && (hz.operand_fwd_i != 2'b00);
  assign aa_valid_s = hz.alu_alu_dh_i  && (hz.operand_fwd_i != 2'b00);

  // Next-state and next-control logic; branch beats load-use beats ALU-ALU.
  always_comb begin
    state_next_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    pending_next_s   = pending_r;
    target_next_s    = pc_target_r;
    fwd_next_s       = 2'b00;
    fwd_src_next_s   = SRC_EXE;
    redirect_next_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (hz.branch_taken_i) begin
          state_next_s     = FLUSH;
          flush_cnt_next_s = FLUSH_RELOAD;
          target_next_s    = hz.target_branch_address_i;
          redirect_next_s  = 1'b1;
        end else if (lu_valid_s) begin
          state_next_s   = LU_STALL;
          pending_next_s = hz.operand_fwd_i;
        end else if (aa_valid_s) begin
          fwd_next_s     = hz.operand_fwd_i;
          fwd_src_next_s = SRC_EXE;
        end else begin
          state_next_s = RUN;
        end
      end
      LU_STALL: begin
        pending_next_s = 2'b00;
        if (hz.branch_taken_i) begin
          state_next_s     = FLUSH;
          flush_cnt_next_s = FLUSH_RELOAD;
          target_next_s    = hz.target_branch_address_i;
          redirect_next_s  = 1'b1;
        end else begin
          state_next_s   = RUN;
          fwd_next_s     = pending_r;
          fwd_src_next_s = SRC_MA;
        end
      end
      FLUSH: begin
        if (hz.branch_taken_i) begin
          flush_cnt_next_s = FLUSH_RELOAD;
          target_next_s    = hz.target_branch_address_i;
          redirect_next_s  = 1'b1;
        end else if (flush_cnt_r == 4'd0) begin
          state_next_s = RUN;
        end else begin
          flush_cnt_next_s = flush_cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s     = RUN;
        flush_cnt_next_s = 4'd0;
        pending_next_s   = 2'b00;
      end
    endcase
  end

  // State, forwarding select and pipeline control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= RUN;
      flush_cnt_r   <= 4'd0;
      pending_r     <= 2'b00;
      fwd_active_r  <= 2'b00;
      fwd_src_r     <= SRC_EXE;
      pc_target_r   <= 32'd0;
      pc_redirect_r <= 1'b0;
      pc_stall_r    <= 1'b0;
      ifid_flush_r  <= 1'b0;
      idex_bubble_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      flush_cnt_r   <= flush_cnt_next_s;
      pending_r     <= pending_next_s;
      fwd_active_r  <= fwd_next_s;
      fwd_src_r     <= fwd_src_next_s;
      pc_target_r   <= target_next_s;
      pc_redirect_r <= redirect_next_s;
      pc_stall_r    <= (state_next_s == LU_STALL);
      ifid_flush_r  <= (state_next_s == FLUSH);
      idex_bubble_r <= (state_next_s == LU_STALL) || (state_next_s == FLUSH);
    end
  end

  // Saturating count of cycles spent stalled or flushing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_count_r <= '0;
    end else if (((state_r == LU_STALL) || (state_r == FLUSH)) && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign hz.pc_stall_o    = pc_stall_r;
  assign hz.ifid_stall_o  = pc_stall_r;
  assign hz.idex_bubble_o = idex_bubble_r;
  assign hz.ifid_flush_o  = ifid_flush_r;
  assign hz.pc_redirect_o = pc_redirect_r;
  assign hz.pc_target_o   = pc_target_r;
  assign hz.fwd_active_o  = fwd_active_r;
  assign hz.stall_count_o = stall_count_r;

  assign hz.alu_op_a_o = fwd_active_r[0] ? ((fwd_src_r == SRC_EXE) ? hz.exe_result_i : hz.ma_load_data_i)
                                         : hz.rs_data_i;
  assign hz.alu_op_b_o = fwd_active_r[1] ? ((fwd_src_r == SRC_EXE) ? hz.exe_result_i : hz.ma_load_data_i)
                                         : hz.rt_data_i;

endmodule

// File: tb/tb_hazard_resolution_unit.sv
// Directed self-checking bench for hazard_resolution_unit; a second instance with a
// 2-bit counter exercises stall-count saturation.
module tb_hazard_resolution_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hazard_resolution_unit_if #(.CNT_W(16)) hif ();
  hazard_resolution_unit_if #(.CNT_W(2))  sif ();

  hazard_resolution_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hif)
  );

  hazard_resolution_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    hif.branch_taken_i = 1'b0;
    hif.load_use_dh_i  = 1'b0;
    hif.alu_alu_dh_i   = 1'b0;
    hif.operand_fwd_i  = 2'b00;
    sif.branch_taken_i = 1'b0;
    sif.load_use_dh_i  = 1'b0;
    sif.alu_alu_dh_i   = 1'b0;
    sif.operand_fwd_i  = 2'b00;
  endtask

  task automatic apply_reset();
    clear_flags();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({hif.pc_stall_o, hif.ifid_stall_o, hif.idex_bubble_o, hif.ifid_flush_o, hif.pc_redirect_o} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {hif.pc_stall_o, hif.ifid_stall_o, hif.idex_bubble_o, hif.ifid_flush_o, hif.pc_redirect_o});
    end
    n_checks++;
    if ({hif.fwd_active_o, hif.pc_target_o, hif.stall_count_o} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_regs: fwd %h target %h count %h expected all 0", hif.fwd_active_o, hif.pc_target_o, hif.stall_count_o);
    end
    n_checks++;
    if (hif.alu_op_a_o !== 32'd5 || hif.alu_op_b_o !== 32'd6) begin
      n_fail++;
      $display("FAIL reset_ops: got %h/%h expected 00000005/00000006", hif.alu_op_a_o, hif.alu_op_b_o);
    end
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_alu_alu();
    apply_reset();
    hif.exe_result_i  = 32'h0000_1234;
    hif.alu_alu_dh_i  = 1'b1;
    hif.operand_fwd_i = 2'b11;
    step();
    clear_flags();
    n_checks++;
    if (hif.alu_op_a_o !== 32'h0000_1234 || hif.alu_op_b_o !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL aa_ops: got %h/%h expected 00001234/00001234", hif.alu_op_a_o, hif.alu_op_b_o);
    end
    n_checks++;
    if (hif.fwd_active_o !== 2'd3) begin
      n_fail++;
      $display("FAIL aa_fwd: got %0d expected 3", hif.fwd_active_o);
    end
    chk1("aa_no_stall", hif.pc_stall_o | hif.idex_bubble_o, 1'b0);
    step();
    n_checks++;
    if (hif.alu_op_a_o !== 32'd5 || hif.alu_op_b_o !== 32'd6 || hif.fwd_active_o !== 2'd0) begin
      n_fail++;
      $display("FAIL aa_release: got %h/%h fwd %0d expected 00000005/00000006 fwd 0", hif.alu_op_a_o, hif.alu_op_b_o, hif.fwd_active_o);
    end
    // Operand B only.
    hif.alu_alu_dh_i  = 1'b1;
    hif.operand_fwd_i = 2'b10;
    step();
    clear_flags();
    n_checks++;
    if (hif.alu_op_a_o !== 32'd5 || hif.alu_op_b_o !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL aa_b_only: got %h/%h expected 00000005/00001234", hif.alu_op_a_o, hif.alu_op_b_o);
    end
  endtask

  task automatic test_ignored();
    apply_reset();
    hif.load_use_dh_i = 1'b1;
    hif.alu_alu_dh_i  = 1'b1;
    hif.operand_fwd_i = 2'b00;
    step();
    clear_flags();
    chk1("ignored_stall", hif.pc_stall_o, 1'b0);
    n_checks++;
    if (hif.fwd_active_o !== 2'd0) begin
      n_fail++;
      $display("FAIL ignored_fwd: got %0d expected 0", hif.fwd_active_o);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    hif.ma_load_data_i = 32'hDEAD_BEEF;
    hif.load_use_dh_i  = 1'b1;
    hif.alu_alu_dh_i   = 1'b1;
    hif.operand_fwd_i  = 2'b01;
    step();
    clear_flags();
    chk1("lu_pc_stall", hif.pc_stall_o, 1'b1);
    chk1("lu_ifid_stall", hif.ifid_stall_o, 1'b1);
    chk1("lu_bubble", hif.idex_bubble_o, 1'b1);
    n_checks++;
    if (hif.fwd_active_o !== 2'd0) begin
      n_fail++;
      $display("FAIL lu_no_early_fwd: got %0d expected 0", hif.fwd_active_o);
    end
    step();
    n_checks++;
    if (hif.alu_op_a_o !== 32'hDEAD_BEEF || hif.alu_op_b_o !== 32'd6 || hif.fwd_active_o !== 2'd1) begin
      n_fail++;
      $display("FAIL lu_fwd: got %h/%h fwd %0d expected deadbeef/00000006 fwd 1", hif.alu_op_a_o, hif.alu_op_b_o, hif.fwd_active_o);
    end
    chk1("lu_release", hif.pc_stall_o | hif.ifid_stall_o | hif.idex_bubble_o, 1'b0);
    n_checks++;
    if (hif.stall_count_o !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_count: got %0d expected 1", hif.stall_count_o);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    hif.branch_taken_i          = 1'b1;
    hif.target_branch_address_i = 32'h0000_0040;
    hif.load_use_dh_i           = 1'b1;
    hif.operand_fwd_i           = 2'b01;
    step();
    clear_flags();
    hif.target_branch_address_i = 32'h0000_0000;
    chk1("br_redirect", hif.pc_redirect_o, 1'b1);
    n_checks++;
    if (hif.pc_target_o !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL br_target: got %h expected 00000040", hif.pc_target_o);
    end
    chk1("br_flush1", hif.ifid_flush_o & hif.idex_bubble_o, 1'b1);
    chk1("br_no_stall1", hif.pc_stall_o | hif.ifid_stall_o, 1'b0);
    step();
    chk1("br_redirect_once", hif.pc_redirect_o, 1'b0);
    chk1("br_flush2", hif.ifid_flush_o & hif.idex_bubble_o, 1'b1);
    chk1("br_no_stall2", hif.pc_stall_o, 1'b0);
    step();
    chk1("br_flush_end", hif.ifid_flush_o | hif.idex_bubble_o, 1'b0);
    n_checks++;
    if (hif.stall_count_o !== 16'd2 || hif.fwd_active_o !== 2'd0) begin
      n_fail++;
      $display("FAIL br_count: got count %0d fwd %0d expected count 2 fwd 0", hif.stall_count_o, hif.fwd_active_o);
    end
  endtask

  task automatic test_lu_then_branch();
    apply_reset();
    hif.ma_load_data_i = 32'hDEAD_BEEF;
    hif.load_use_dh_i  = 1'b1;
    hif.operand_fwd_i  = 2'b01;
    step();
    clear_flags();
    chk1("lub_stall", hif.pc_stall_o, 1'b1);
    hif.branch_taken_i          = 1'b1;
    hif.target_branch_address_i = 32'h0000_0080;
    step();
    clear_flags();
    chk1("lub_redirect", hif.pc_redirect_o, 1'b1);
    chk1("lub_flush", hif.ifid_flush_o, 1'b1);
    chk1("lub_no_stall", hif.pc_stall_o, 1'b0);
    n_checks++;
    if (hif.pc_target_o !== 32'h0000_0080 || hif.alu_op_a_o !== 32'd5) begin
      n_fail++;
      $display("FAIL lub_target: got %h op_a %h expected 00000080 op_a 00000005", hif.pc_target_o, hif.alu_op_a_o);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (hif.fwd_active_o !== 2'd0 || hif.alu_op_a_o !== 32'd5) begin
        n_fail++;
        $display("FAIL lub_no_ma_fwd: cycle %0d fwd %0d op_a %h expected fwd 0 op_a 00000005", i, hif.fwd_active_o, hif.alu_op_a_o);
      end
    end
    chk1("lub_flush_end", hif.ifid_flush_o, 1'b0);
  endtask

  task automatic test_reset_mid_flush();
    apply_reset();
    hif.branch_taken_i          = 1'b1;
    hif.target_branch_address_i = 32'h0000_0100;
    step();
    clear_flags();
    step();
    chk1("rmf_in_flush", hif.ifid_flush_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({hif.pc_stall_o, hif.ifid_stall_o, hif.idex_bubble_o, hif.ifid_flush_o, hif.pc_redirect_o} !== 5'b00000
        || hif.pc_target_o !== 32'd0 || hif.stall_count_o !== 16'd0 || hif.fwd_active_o !== 2'd0) begin
      n_fail++;
      $display("FAIL rmf_async: ctrl %b target %h count %0d fwd %0d expected all 0",
               {hif.pc_stall_o, hif.ifid_stall_o, hif.idex_bubble_o, hif.ifid_flush_o, hif.pc_redirect_o},
               hif.pc_target_o, hif.stall_count_o, hif.fwd_active_o);
    end
    #1;
    rst = 1'b0;
    step();
    chk1("rmf_no_residual", hif.ifid_flush_o | hif.idex_bubble_o | hif.pc_redirect_o, 1'b0);
    step();
    chk1("rmf_no_residual2", hif.ifid_flush_o | hif.idex_bubble_o, 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    sif.load_use_dh_i = 1'b1;
    sif.operand_fwd_i = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 4) begin
        n_checks++;
        if (sif.stall_count_o !== 2'd2) begin
          n_fail++;
          $display("FAIL sat_mid: got %0d expected 2", sif.stall_count_o);
        end
      end
      if (i == 6 || i == 10) begin
        n_checks++;
        if (sif.stall_count_o !== 2'd3) begin
          n_fail++;
          $display("FAIL sat_hold: cycle %0d got %0d expected 3", i, sif.stall_count_o);
        end
      end
    end
    clear_flags();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_flags();
    hif.target_branch_address_i = 32'd0;
    hif.rs_data_i      = 32'd5;
    hif.rt_data_i      = 32'd6;
    hif.exe_result_i   = 32'h0000_1234;
    hif.ma_load_data_i = 32'hDEAD_BEEF;
    sif.target_branch_address_i = 32'd0;
    sif.rs_data_i      = 32'd1;
    sif.rt_data_i      = 32'd2;
    sif.exe_result_i   = 32'd3;
    sif.ma_load_data_i = 32'd4;
    test_reset();
    test_alu_alu();
    test_ignored();
    test_load_use();
    test_branch();
    test_lu_then_branch();
    test_reset_mid_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
